// File: rtl/prog_seq_gen.sv
// prog_seq_gen: programmable table sequencer with wrap, ping-pong, one-shot and hold modes
module prog_seq_gen #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    last_idx,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic [WIDTH-1:0] out,
  output logic [AW-1:0]    idx,
  output logic             wrap,
  output logic             done
);
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [AW-1:0] nxt;
  logic dir_down, nxt_down, nxt_wrap, nxt_done, load;
  logic at_end;
  assign at_end = idx >= last_idx;
  always_comb begin
    nxt = idx;
    nxt_down = dir_down;
    nxt_wrap = 1'b0;
    nxt_done = done;
    load = 1'b0;
    if (restart) begin
      nxt = '0;
      nxt_down = 1'b0;
      nxt_done = 1'b0;
      load = 1'b1;
    end else if (en) begin
      case (mode)
        2'b00: begin
          load = 1'b1;
          nxt = at_end ? '0 : idx + AW'(1);
          nxt_wrap = at_end;
        end
        2'b01: begin
          load = 1'b1;
          // a one-entry sequence never turns around; it just re-wraps on entry 0
          if (last_idx == '0) begin
            nxt = '0;
            nxt_down = 1'b0;
            nxt_wrap = 1'b1;
          end else if (!dir_down) begin
            nxt = !at_end ? idx + AW'(1) : (idx > last_idx ? last_idx : idx - AW'(1));
            nxt_down = at_end;
          end else if (idx == '0) begin
            nxt = AW'(1);
            nxt_down = 1'b0;
            nxt_wrap = 1'b1;
          end else begin
            nxt = idx - AW'(1);
          end
        end
        2'b10: begin
          if (!done) begin
            nxt_done = at_end;
            load = !at_end;
            nxt = at_end ? idx : idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= WIDTH'(i == 1 ? 2 : i == 2 ? 3 : i == 3 ? 5 : 0);
      idx <= '0;
      dir_down <= 1'b0;
      out <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      if (cfg_we) tbl[cfg_addr] <= cfg_data;
      idx <= nxt;
      dir_down <= nxt_down;
      wrap <= nxt_wrap;
      done <= nxt_done;
      if (load) out <= (cfg_we && cfg_addr == nxt) ? cfg_data : tbl[nxt];
    end
  end
endmodule

// File: tb/tb_prog_seq_gen.sv
// tb_prog_seq_gen: directed test-plan sequences plus random traffic against a behavioural model
module tb_prog_seq_gen;
  logic clk, rst, en, restart, cfg_we, wrap, done;
  logic [1:0] mode;
  logic [2:0] last_idx, cfg_addr, cfg_data, out, idx;
  int n_vec, n_err;
  int mt [8];
  int mi, mo;
  bit mdn, mw, md;

  prog_seq_gen #(.WIDTH(3), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .mode(mode),
    .last_idx(last_idx), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out(out), .idx(idx), .wrap(wrap), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of the documented step rules; the table write lands first so a
  // same-edge write to the new index is naturally what gets loaded.
  task automatic model(input bit r, e, rs, input int m, li, input bit w, input int a, d);
    int ni;
    bit ld;
    if (r) begin
      mt = '{0, 2, 3, 5, 0, 0, 0, 0};
      mi = 0; mdn = 0; mo = 0; mw = 0; md = 0;
      return;
    end
    ni = mi; ld = 0; mw = 0;
    if (rs) begin
      ni = 0; mdn = 0; md = 0; ld = 1;
    end else if (e) begin
      if (m == 0) begin
        ld = 1;
        if (mi >= li) begin ni = 0; mw = 1; end else ni = mi + 1;
      end else if (m == 1) begin
        ld = 1;
        if (li == 0) begin ni = 0; mw = 1; mdn = 0; end
        else if (!mdn) begin
          if (mi >= li) begin mdn = 1; ni = (mi - 1 < li) ? mi - 1 : li; end
          else ni = mi + 1;
        end else if (mi == 0) begin mdn = 0; ni = 1; mw = 1; end
        else ni = mi - 1;
      end else if (m == 2 && !md) begin
        if (mi >= li) md = 1; else begin ld = 1; ni = mi + 1; end
      end
    end
    if (w) mt[a] = d;
    if (ld) mo = mt[ni];
    mi = ni;
  endtask

  task automatic cyc(input bit r, e, rs, input int m, li, input bit w, input int a, d);
    @(negedge clk);
    rst = r; en = e; restart = rs; mode = 2'(m); last_idx = 3'(li);
    cfg_we = w; cfg_addr = 3'(a); cfg_data = 3'(d);
    @(posedge clk);
    model(r, e, rs, m, li, w, a, d);
    #1;
    chk("out", int'(out), mo);
    chk("idx", int'(idx), mi);
    chk("wrap", int'(wrap), int'(mw));
    chk("done", int'(done), int'(md));
  endtask

  initial begin
    int exp_a [7];
    n_vec = 0; n_err = 0;
    mi = 0; mo = 0; mdn = 0; mw = 0; md = 0;
    rst = 1; en = 0; restart = 0; mode = 0; last_idx = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    cyc(1, 0, 0, 0, 3, 0, 0, 0);
    chk("rst_out", int'(out), 0);
    chk("rst_idx", int'(idx), 0);
    // legacy sequence
    exp_a = '{2, 3, 5, 0, 2, 3, 5};
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 0, 3, 0, 0, 0);
      chk("legacy_out", int'(out), exp_a[i]);
      chk("legacy_wrap", int'(wrap), int'(i == 3));
    end
    // programming
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 5, 1, i, i + 1);
    cyc(0, 0, 1, 0, 5, 0, 0, 0);
    chk("prog_restart_out", int'(out), 1);
    exp_a = '{2, 3, 4, 5, 6, 1, 2};
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 0, 5, 0, 0, 0);
      chk("prog_out", int'(out), exp_a[i]);
    end
    cyc(0, 0, 0, 0, 5, 1, 2, 7);
    chk("prog_no_refresh", int'(out), 2);
    cyc(0, 1, 0, 0, 5, 0, 0, 0);
    chk("prog_new_visit", int'(out), 7);
    // ping-pong on the legacy table
    cyc(1, 0, 0, 0, 3, 0, 0, 0);
    exp_a = '{1, 2, 3, 2, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 1, 3, 0, 0, 0);
      chk("pp_idx", int'(idx), exp_a[i]);
    end
    // one-shot
    cyc(0, 0, 1, 2, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 2, 2, 0, 0, 0);
    chk("os_idx", int'(idx), 2);
    chk("os_done", int'(done), 1);
    cyc(0, 1, 1, 2, 2, 0, 0, 0);
    chk("os_restart_idx", int'(idx), 0);
    chk("os_restart_done", int'(done), 0);
    // enable toggling, hold mode, priorities
    cyc(0, 1, 0, 0, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 3, 0, 0, 0);
    chk("en_off_idx", int'(idx), 1);
    cyc(0, 1, 0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3, 3, 0, 0, 0);
    chk("hold_idx", int'(idx), 2);
    cyc(0, 1, 0, 1, 3, 0, 0, 0);
    cyc(1, 1, 1, 1, 3, 1, 0, 6);
    chk("rst_prio_out", int'(out), 0);
    // last_idx shrink below idx
    cyc(0, 0, 1, 0, 7, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 7, 0, 0, 0);
    chk("shrink_pre", int'(idx), 5);
    cyc(0, 1, 0, 0, 2, 0, 0, 0);
    chk("shrink_idx", int'(idx), 0);
    chk("shrink_wrap", int'(wrap), 1);
    // write bypass on restart
    cyc(0, 1, 1, 0, 3, 1, 0, 6);
    chk("bypass_out", int'(out), 6);
    // one-entry ping-pong
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 1, 0, 0, 0, 0);
      chk("pp0_out", int'(out), 6);
      chk("pp0_wrap", int'(wrap), 1);
    end
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(19) == 0,
          $urandom_range(3), $urandom_range(7), $urandom_range(3) == 0,
          $urandom_range(7), $urandom_range(7));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
